// File: rtl/alu_pkg.sv
// Shared opcode encodings and the status-flag bundle for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic carry;  // carry-out / borrow / last bit shifted out
    logic zero;   // result == 0
    logic neg;    // result MSB
    logic ovf;    // signed overflow (ADD/SUB only)
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU datapath.
// Ports:
//   a, b    operands; the low SHW bits of b are the shift amount
//   op      operation select
//   result  WIDTH-bit result, modulo 2^WIDTH
//   flags   carry / zero / neg / ovf for the result
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SHW-1:0] shamt;
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;
  logic [WIDTH:0] shl_w;
  logic [WIDTH:0] shr_w;
  logic           sh_oor;
  logic           carry;
  logic           ovf;

  assign shamt  = b[SHW-1:0];
  assign sum_w  = {1'b0, a} + {1'b0, b};
  // MSB of the widened difference is 1 exactly when a < b unsigned.
  assign diff_w = {1'b0, a} - {1'b0, b};
  // One extra bit on the outgoing side captures the last bit shifted out;
  // a zero shift leaves that bit at 0.
  assign shl_w  = {1'b0, a} << shamt;
  assign shr_w  = {a, 1'b0} >> shamt;
  // Only reachable when WIDTH is not a power of two.
  assign sh_oor = ({{(32-SHW){1'b0}}, shamt} >= 32'(WIDTH));

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        {carry, result} = sum_w;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {carry, result} = diff_w;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOT: result = ~a;
      OP_XOR: result = a ^ b;
      OP_SHL: if (!sh_oor) {carry, result} = shl_w;
      OP_SHR: if (!sh_oor) {result, carry} = shr_w;
      default: result = '0;
    endcase
  end

  assign flags = '{carry: carry, zero: (result == '0), neg: result[WIDTH-1], ovf: ovf};

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage pipelined ALU with valid/ready on both sides and an accumulator.
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      request handshake; in_a, in_b, in_op, in_acc payload
//   acc_clr                synchronous accumulator clear
//   out_valid/out_ready    result handshake; out_result + out_carry/zero/neg/ovf
//   acc_out                current accumulator value
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_out
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic             s1_acc;
  logic [WIDTH-1:0] acc;

  logic             s2_load;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;
  // The accumulator is read when the op leaves stage 1, not when it is
  // accepted, so back-to-back accumulate ops see each other's results.
  assign alu_a    = s1_acc ? acc : s1_a;
  assign acc_out  = acc;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (alu_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_acc   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= alu_op_e'(in_op);
      s1_acc   <= in_acc;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= alu_res;
        out_carry  <= alu_flags.carry;
        out_zero   <= alu_flags.zero;
        out_neg    <= alu_flags.neg;
        out_ovf    <= alu_flags.ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (s1_adv && s1_acc) begin
      acc <= alu_res;
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
module tb_pipelined_alu;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       o;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_acc;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_neg;
  logic       out_ovf;
  logic [7:0] acc_out;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  pipelined_alu #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_acc     (in_acc),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf),
    .acc_out    (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every consumed beat and checks that a
  // stalled output holds still.
  exp_t cur;
  exp_t held;
  exp_t e;
  logic held_pending = 1'b0;

  always @(negedge clk) begin
    cur = '{r: out_result, c: out_carry, z: out_zero, n: out_neg, o: out_ovf};
    if (!rst_n) begin
      held_pending = 1'b0;
    end else begin
      if (held_pending)
        chk("hold_stable", {19'd0, out_valid, cur}, {19'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %h expected none", cur);
        end else begin
          e = sb.pop_front();
          chk("result_flags", {20'd0, cur}, {20'd0, e});
        end
      end
      held_pending = out_valid && !out_ready;
      held = cur;
    end
  end

  // Presents one request, waits (bounded) for acceptance, then records the
  // expected response if push is set. Returns at accept edge + 1.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic acc, input logic push,
                       input logic [7:0] er, input logic ec, input logic ez,
                       input logic en, input logic eo);
    int unsigned n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = acc;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got in_ready=0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_acc   = 1'b0;
    if (push) sb.push_back('{r: er, c: ec, z: ez, n: en, o: eo});
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_acc    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_out_result", out_result, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // basic ops: {result, carry, zero, neg, ovf}
    issue(8'hF0, 8'h20, 3'b000, 0, 1, 8'h10, 1, 0, 0, 0);
    issue(8'h80, 8'h01, 3'b001, 0, 1, 8'h7F, 0, 0, 0, 1);
    issue(8'h03, 8'h05, 3'b001, 0, 1, 8'hFE, 1, 0, 1, 0);
    issue(8'h0F, 8'hF0, 3'b010, 0, 1, 8'h00, 0, 1, 0, 0);
    issue(8'h0F, 8'h30, 3'b011, 0, 1, 8'h3F, 0, 0, 0, 0);
    issue(8'h5A, 8'h00, 3'b100, 0, 1, 8'hA5, 0, 0, 1, 0);
    issue(8'hFF, 8'h0F, 3'b101, 0, 1, 8'hF0, 0, 0, 1, 0);
    issue(8'h7F, 8'h01, 3'b000, 0, 1, 8'h80, 0, 0, 1, 1);
    issue(8'h05, 8'h05, 3'b001, 0, 1, 8'h00, 0, 1, 0, 0);
    // shifts
    issue(8'h81, 8'h01, 3'b110, 0, 1, 8'h02, 1, 0, 0, 0);
    issue(8'h81, 8'h00, 3'b111, 0, 1, 8'h81, 0, 0, 1, 0);
    issue(8'h81, 8'h09, 3'b111, 0, 1, 8'h40, 1, 0, 0, 0);
    issue(8'h81, 8'h07, 3'b110, 0, 1, 8'h80, 0, 0, 1, 0);
    drain();

    // backpressure: two accepted, then in_ready drops until release
    out_ready = 1'b0;
    fork
      begin
        issue(8'h00, 8'h01, 3'b000, 0, 1, 8'h01, 0, 0, 0, 0);
        issue(8'h00, 8'h02, 3'b000, 0, 1, 8'h02, 0, 0, 0, 0);
        issue(8'h00, 8'h03, 3'b000, 0, 1, 8'h03, 0, 0, 0, 0);
        issue(8'h00, 8'h04, 3'b000, 0, 1, 8'h04, 0, 0, 0, 0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_queued", sb.size(), 2);
        out_ready = 1'b1;
      end
    join
    drain();

    // accumulator chain; in_a is ignored in accumulate mode
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    chk("acc_after_clr", acc_out, 0);
    issue(8'hFF, 8'h05, 3'b000, 1, 1, 8'h05, 0, 0, 0, 0);
    issue(8'hFF, 8'h05, 3'b000, 1, 1, 8'h0A, 0, 0, 0, 0);
    issue(8'hFF, 8'h05, 3'b000, 1, 1, 8'h0F, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("acc_chain", acc_out, 8'h0F);
    // clear coincides with the 4th op leaving stage 1: result still delivered
    issue(8'hFF, 8'h05, 3'b000, 1, 1, 8'h14, 0, 0, 0, 0);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    chk("acc_clr_wins", acc_out, 8'h00);
    drain();
    issue(8'h00, 8'h07, 3'b000, 1, 1, 8'h07, 0, 0, 0, 0);
    drain();
    chk("acc_reload", acc_out, 8'h07);

    // reset with both stages full: everything in flight is discarded
    out_ready = 1'b0;
    issue(8'h11, 8'h11, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);
    issue(8'h22, 8'h22, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0);
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_acc_out", acc_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_stale_output", out_valid, 0);
    issue(8'h01, 8'h01, 3'b000, 0, 1, 8'h02, 0, 0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
